// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// encoding table, blank pattern and controller state type.
package sseg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } ctrl_state_t;

  // Active-low {a,b,c,d,e,f,g}; all segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n holds the segment pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 32-bit binary to 10 BCD digits in
// exactly 32 busy cycles. The bcd output is the value the converter is
// about to register; it is the final result in the cycle done is high,
// so a consumer can capture it on the same edge the conversion ends.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] bin_q;
  logic [39:0] bcd_q;
  logic [39:0] bcd_adj;
  logic [4:0]  cnt;

  // Add-3 correction for every digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd  = {bcd_adj[38:0], bin_q[31]};
  assign done = busy && (cnt == 5'd31);

  // Capture the operand on start, then shift one bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (!busy) begin
      if (start) begin
        busy  <= 1'b1;
        cnt   <= '0;
        bin_q <= bin_in;
        bcd_q <= '0;
      end
    end else begin
      bcd_q <= bcd;
      bin_q <= bin_q << 1;
      cnt   <= cnt + 5'd1;
      if (cnt == 5'd31)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment controller with a load/ready
// handshake. Hex values commit immediately; decimal values go through the
// BCD converter and commit atomically when it finishes.
//
//   state | meaning
//   IDLE  | ready for a load; hex loads commit here
//   CONV  | BCD conversion running; loads ignored
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int LEAD_BLANK = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  output logic        ready,
  input  logic [31:0] value,
  input  logic        dec,
  output logic [6:0]  segments,
  output logic [7:0]  anodes,
  output logic        ovf
);

  localparam int PW = $clog2(SCAN_DIV);

  ctrl_state_t state, state_nxt;
  logic [31:0] disp, disp_nxt;
  logic        ovf_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [3:0]  nib_nxt;
  logic        blank_nxt;

  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [39:0] conv_bcd;

  assign ready      = (state == IDLE);
  assign conv_start = ready && load && dec;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .bin_in (value),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  // Digit i>0 is dark when it and every more significant digit are zero.
  function automatic logic is_blank(input logic [31:0] d, input logic [2:0] i);
    logic b;
    b = (LEAD_BLANK != 0) && (i != 3'd0);
    for (int k = 0; k < 8; k++) begin
      if ((k >= int'(i)) && (d[4*k +: 4] != 4'd0))
        b = 1'b0;
    end
    return b;
  endfunction

  // Next state, display register and overflow flag.
  always_comb begin
    state_nxt = state;
    disp_nxt  = disp;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (load) begin
          if (dec) begin
            state_nxt = CONV;
          end else begin
            disp_nxt = value;
            ovf_nxt  = 1'b0;
          end
        end
      end
      CONV: begin
        if (conv_done) begin
          state_nxt = IDLE;
          ovf_nxt   = |conv_bcd[39:32];
          disp_nxt  = ovf_nxt ? 32'hEEEE_EEEE : conv_bcd[31:0];
        end else if (!conv_busy) begin
          // Converter lost its run without finishing; nothing to commit.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler and digit index; free-running, independent of the handshake.
  always_comb begin
    pre_nxt = pre + PW'(1);
    idx_nxt = idx;
    if (pre == PW'(SCAN_DIV - 1)) begin
      pre_nxt = '0;
      idx_nxt = idx + 3'd1;
    end
    nib_nxt   = disp_nxt[4*idx_nxt +: 4];
    blank_nxt = is_blank(disp_nxt, idx_nxt);
  end

  // Controller, display and scan state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      disp  <= '0;
      ovf   <= 1'b0;
      pre   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      disp  <= disp_nxt;
      ovf   <= ovf_nxt;
      pre   <= pre_nxt;
      idx   <= idx_nxt;
    end
  end

  // Outputs registered from next-state values so anodes and segments
  // change together on the edge the index or display changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes   <= 8'hFE;
      segments <= 7'b0000001;
    end else if (blank_nxt) begin
      anodes   <= 8'hFF;
      segments <= SEG_BLANK;
    end else begin
      anodes   <= ~(8'b1 << idx_nxt);
      segments <= seg_encode(nib_nxt);
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: decodes the scanned segment/anode
// stream back into a number and checks it against hand-computed values.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        dec;
  logic [31:0] value;
  logic        rdy0, rdy1, ovf0, ovf1;
  logic [6:0]  sg0, sg1;
  logic [7:0]  an0, an1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.SCAN_DIV(4), .LEAD_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .ready(rdy0), .value(value),
    .dec(dec), .segments(sg0), .anodes(an0), .ovf(ovf0)
  );

  sseg_scan_ctrl #(.SCAN_DIV(4), .LEAD_BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .ready(rdy1), .value(value),
    .dec(dec), .segments(sg1), .anodes(an1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Segment pattern back to a digit; 5'h10 = blank, 5'h1F = not a digit.
  function automatic logic [4:0] seg2nib(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h0;
      7'b1001111: return 5'h1;
      7'b0010010: return 5'h2;
      7'b0000110: return 5'h3;
      7'b1001100: return 5'h4;
      7'b0100100: return 5'h5;
      7'b0100000: return 5'h6;
      7'b0001111: return 5'h7;
      7'b0000000: return 5'h8;
      7'b0000100: return 5'h9;
      7'b0001000: return 5'hA;
      7'b1100000: return 5'hB;
      7'b0110001: return 5'hC;
      7'b1000010: return 5'hD;
      7'b0110000: return 5'hE;
      7'b0111000: return 5'hF;
      7'b1111111: return 5'h10;
      default:    return 5'h1F;
    endcase
  endfunction

  // Watch one full scan (32 cycles) of one DUT and rebuild the number.
  task automatic observe(input bit sel, output logic [31:0] hexv, output longint decv,
                         output int bad, output int onehot_err, output int rot_err,
                         output logic [7:0] ever_low);
    logic [7:0] an;
    logic [6:0] sg;
    logic [4:0] n;
    logic [3:0] dig [8];
    int hist [32];
    bad = 0; onehot_err = 0; rot_err = 0; ever_low = 8'h00;
    for (int j = 0; j < 8; j++) dig[j] = 4'h0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      an = sel ? an1 : an0;
      sg = sel ? sg1 : sg0;
      ever_low = ever_low | ~an;
      hist[k] = -1;
      if ($countones(~an) == 1) begin
        for (int j = 0; j < 8; j++) if (!an[j]) hist[k] = j;
        n = seg2nib(sg);
        if (n[4]) bad++;
        else dig[hist[k]] = n[3:0];
      end else begin
        if (!sel || an != 8'hFF) onehot_err++;
        if (an == 8'hFF && sg != 7'b1111111) bad++;
      end
      if (k >= 4 && hist[k] >= 0 && hist[k-4] >= 0 && hist[k] != (hist[k-4] + 1) % 8)
        rot_err++;
    end
    hexv = {dig[7], dig[6], dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
    decv = 0;
    for (int j = 7; j >= 0; j--) decv = decv * 10 + longint'(dig[j]);
  endtask

  // Present a load at a falling edge; it is accepted on the next rising edge.
  task automatic do_load(input logic [31:0] v, input logic d, input string tag);
    value = v; dec = d; load = 1'b1;
    chk({tag, "_ready"}, rdy0, 1'b1);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Count cycles with ready low, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  logic [31:0] hv;
  longint      dv;
  int          bad, oh, rot, n;
  logic [7:0]  low;

  initial begin
    rst = 1'b1; load = 1'b0; dec = 1'b0; value = '0;
    #1;
    chk("rst_anodes", an0, 8'hFE);
    chk("rst_segments", sg0, 7'b0000001);
    chk("rst_ready", {rdy1, rdy0}, 2'b11);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_anodes_lb", an1, 8'hFE);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Hex load
    do_load(32'h12AB_CDEF, 1'b0, "hex1");
    chk("hex1_ovf", ovf0, 1'b0);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("hex1_value", hv, 32'h12AB_CDEF);
    chk("hex1_onehot", oh, 0);
    chk("hex1_rotate", rot, 0);
    chk("hex1_badseg", bad, 0);

    // Decimal load
    do_load(32'd12345678, 1'b1, "dec1");
    wait_ready(n);
    chk("dec1_busy_cycles", n, 32);
    chk("dec1_ovf", ovf0, 1'b0);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("dec1_value", dv, 64'd12345678);
    chk("dec1_badseg", bad, 0);

    // Decimal overflow then hex zero
    do_load(32'd100_000_000, 1'b1, "ovf");
    wait_ready(n);
    chk("ovf_busy_cycles", n, 32);
    chk("ovf_flag", ovf0, 1'b1);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("ovf_digits_e", hv, 32'hEEEE_EEEE);
    do_load(32'h0, 1'b0, "zero");
    chk("zero_ovf", ovf0, 1'b0);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("zero_value", hv, 32'h0);

    // Load pulsed and inputs changed during conversion
    do_load(32'd11111111, 1'b1, "ign");
    n = 0;
    while (!rdy0 && n < 200) begin
      if (n == 5) begin
        load = 1'b1; value = 32'd99; dec = 1'b0;
      end else if (n == 6) begin
        load = 1'b0; value = 32'hDEAD_BEEF; dec = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    chk("ign_busy_cycles", n, 32);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("ign_value", dv, 64'd11111111);

    // Reset in the middle of a conversion
    do_load(32'd55555555, 1'b1, "abort");
    repeat (9) @(negedge clk);
    chk("abort_in_conv", rdy0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort_anodes", an0, 8'hFE);
    chk("abort_segments", sg0, 7'b0000001);
    chk("abort_ready", rdy0, 1'b1);
    chk("abort_ovf", ovf0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_ready_after", rdy0, 1'b1);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("abort_no_commit", hv, 32'h0);

    // Leading-zero blanking
    do_load(32'h0000_0042, 1'b0, "blank");
    observe(1'b1, hv, dv, bad, oh, rot, low);
    chk("blank_high_anodes", low[7:2], 6'h00);
    chk("blank_lb_value", hv, 32'h42);
    chk("blank_lb_badseg", bad + oh, 0);
    observe(1'b0, hv, dv, bad, oh, rot, low);
    chk("blank_nolb_value", hv, 32'h42);
    chk("blank_nolb_allseen", low, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
